// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite slave memory: response codes, channel FSM states, latency limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axil_pkg;

   // Largest supported wait-state count per channel; sizes the latency counters.
   localparam int LAT_MAX = 15;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_e;

endpackage

// File: rtl/axil_mem_array.sv
// DEPTH x DATA_W word array, one write port with byte enables and one synchronous read port.
// Latency: read data appears the cycle after rd_en; a same-edge read of the word being written returns old data.
// Backpressure: none; the read register holds its value while rd_en is low.
// Ports: clk; wr_en/wr_idx/wr_dat/wr_be write port; rd_en/rd_idx read request; rd_dat registered read data.
module axil_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AIW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AIW-1:0]        wr_idx,
   input  logic [DATA_W-1:0]     wr_dat,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic                  rd_en,
   input  logic [AIW-1:0]        rd_idx,
   output logic [DATA_W-1:0]     rd_dat
);

   localparam int BYTES = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_dat_q;
   logic [DATA_W-1:0] rd_dat_d;

   always_comb begin
      rd_dat_d = rd_dat_q;
      if (rd_en) begin
         rd_dat_d = mem[rd_idx];
      end
   end

   // Storage is never reset; the read register only updates on a read request.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b]) begin
               mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
            end
         end
      end
      rd_dat_q <= rd_dat_d;
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/axil_slave_mem.sv
// AXI-Lite slave memory with byte strobes, SLVERR decode errors and per-channel wait states.
// Latency: AW+W complete to bvalid 1+WRITE_LAT cycles; AR to rvalid 1+READ_LAT cycles.
// Backpressure: bready/rready low holds the response and blocks new requests on that channel only.
// Ports: clk, reset (sync, active high); mem_axi_aw*/w*/b* write channels; mem_axi_ar*/r* read channels.
module axil_slave_mem
   import axil_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 1024,
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_axi_awvalid,
   output logic                  mem_axi_awready,
   input  logic [ADDR_W-1:0]     mem_axi_awaddr,
   input  logic [2:0]            mem_axi_awprot,
   input  logic                  mem_axi_wvalid,
   output logic                  mem_axi_wready,
   input  logic [DATA_W-1:0]     mem_axi_wdata,
   input  logic [DATA_W/8-1:0]   mem_axi_wstrb,
   output logic                  mem_axi_bvalid,
   input  logic                  mem_axi_bready,
   output logic [1:0]            mem_axi_bresp,
   input  logic                  mem_axi_arvalid,
   output logic                  mem_axi_arready,
   input  logic [ADDR_W-1:0]     mem_axi_araddr,
   input  logic [2:0]            mem_axi_arprot,
   output logic                  mem_axi_rvalid,
   input  logic                  mem_axi_rready,
   output logic [DATA_W-1:0]     mem_axi_rdata,
   output logic [1:0]            mem_axi_rresp
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int IW    = ADDR_W - OFF;
   localparam int AIW   = $clog2(DEPTH);
   localparam logic [IW-1:0]    DEPTH_IDX = IW'(DEPTH);
   localparam logic [CNT_W-1:0] W_LOAD    = CNT_W'((WRITE_LAT > 0) ? WRITE_LAT - 1 : 0);
   localparam logic [CNT_W-1:0] R_LOAD    = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);

   if (READ_LAT < 0 || READ_LAT > LAT_MAX) begin : g_bad_read_lat
      $error("axil_slave_mem: READ_LAT must be within 0..15");
   end
   if (WRITE_LAT < 0 || WRITE_LAT > LAT_MAX) begin : g_bad_write_lat
      $error("axil_slave_mem: WRITE_LAT must be within 0..15");
   end
   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("axil_slave_mem: DATA_W must be 32 or 64");
   end

   // Protection bits and sub-word address bits carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_awaddr[OFF-1:0], mem_axi_araddr[OFF-1:0]};

   // ---------------- write channel ----------------
   wr_state_e         wr_state_q, wr_state_d;
   logic              aw_cap_q, aw_cap_d;
   logic              w_cap_q, w_cap_d;
   logic [IW-1:0]     awidx_q, awidx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BYTES-1:0]  wstrb_q, wstrb_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   axil_resp_e        bresp_q, bresp_d;
   logic              wr_commit;
   logic              awready_i, wready_i;
   logic              aw_hs, w_hs;

   // Readies are forced low during reset so nothing is accepted on that edge.
   assign awready_i = !reset && (wr_state_q == W_IDLE) && !aw_cap_q;
   assign wready_i  = !reset && (wr_state_q == W_IDLE) && !w_cap_q;
   assign aw_hs     = mem_axi_awvalid && awready_i;
   assign w_hs      = mem_axi_wvalid && wready_i;

   always_comb begin
      wr_state_d = wr_state_q;
      aw_cap_d   = aw_cap_q;
      w_cap_d    = w_cap_q;
      awidx_d    = awidx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wcnt_d     = wcnt_q;
      bresp_d    = bresp_q;
      wr_commit  = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_cap_d = 1'b1;
               awidx_d  = mem_axi_awaddr[ADDR_W-1:OFF];
            end
            if (w_hs) begin
               w_cap_d = 1'b1;
               wdata_d = mem_axi_wdata;
               wstrb_d = mem_axi_wstrb;
            end
            // The second half may arrive on this very edge, so test the next-state flags.
            if (aw_cap_d && w_cap_d) begin
               if (WRITE_LAT == 0) begin
                  wr_state_d = W_RESP;
                  wr_commit  = 1'b1;
               end else begin
                  wr_state_d = W_WAIT;
                  wcnt_d     = W_LOAD;
               end
            end
         end
         W_WAIT: begin
            if (wcnt_q == '0) begin
               wr_state_d = W_RESP;
               wr_commit  = 1'b1;
            end else begin
               wcnt_d = wcnt_q - CNT_W'(1);
            end
         end
         W_RESP: begin
            if (mem_axi_bready) begin
               wr_state_d = W_IDLE;
               aw_cap_d   = 1'b0;
               w_cap_d    = 1'b0;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
      if (wr_commit) begin
         bresp_d = (awidx_d >= DEPTH_IDX) ? SLVERR : OKAY;
      end
   end

   // ---------------- read channel ----------------
   rd_state_e         rd_state_q, rd_state_d;
   logic [IW-1:0]     aridx_q, aridx_d;
   logic [CNT_W-1:0]  rcnt_q, rcnt_d;
   axil_resp_e        rresp_q, rresp_d;
   logic              rd_sample;
   logic              arready_i;
   logic              ar_hs;

   assign arready_i = !reset && (rd_state_q == R_IDLE);
   assign ar_hs     = mem_axi_arvalid && arready_i;

   always_comb begin
      rd_state_d = rd_state_q;
      aridx_d    = aridx_q;
      rcnt_d     = rcnt_q;
      rresp_d    = rresp_q;
      rd_sample  = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               aridx_d = mem_axi_araddr[ADDR_W-1:OFF];
               if (READ_LAT == 0) begin
                  rd_state_d = R_RESP;
                  rd_sample  = 1'b1;
               end else begin
                  rd_state_d = R_WAIT;
                  rcnt_d     = R_LOAD;
               end
            end
         end
         R_WAIT: begin
            if (rcnt_q == '0) begin
               rd_state_d = R_RESP;
               rd_sample  = 1'b1;
            end else begin
               rcnt_d = rcnt_q - CNT_W'(1);
            end
         end
         R_RESP: begin
            if (mem_axi_rready) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
      if (rd_sample) begin
         rresp_d = (aridx_d >= DEPTH_IDX) ? SLVERR : OKAY;
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_q <= W_IDLE;
         aw_cap_q   <= 1'b0;
         w_cap_q    <= 1'b0;
         awidx_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wcnt_q     <= '0;
         bresp_q    <= OKAY;
         rd_state_q <= R_IDLE;
         aridx_q    <= '0;
         rcnt_q     <= '0;
         rresp_q    <= OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_cap_q   <= aw_cap_d;
         w_cap_q    <= w_cap_d;
         awidx_q    <= awidx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wcnt_q     <= wcnt_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         aridx_q    <= aridx_d;
         rcnt_q     <= rcnt_d;
         rresp_q    <= rresp_d;
      end
   end

   // ---------------- storage ----------------
   logic [DATA_W-1:0] arr_rdata;

   // Out-of-range writes never reach the array; a reset edge cancels a pending commit.
   axil_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AIW    (AIW)
   ) u_array (
      .clk    (clk),
      .wr_en  (wr_commit && !reset && (awidx_d < DEPTH_IDX)),
      .wr_idx (awidx_d[AIW-1:0]),
      .wr_dat (wdata_d),
      .wr_be  (wstrb_d),
      .rd_en  (rd_sample && !reset),
      .rd_idx (aridx_d[AIW-1:0]),
      .rd_dat (arr_rdata)
   );

   // ---------------- outputs ----------------
   always_comb begin
      mem_axi_awready = awready_i;
      mem_axi_wready  = wready_i;
      mem_axi_arready = arready_i;
      mem_axi_bvalid  = !reset && (wr_state_q == W_RESP);
      mem_axi_bresp   = mem_axi_bvalid ? bresp_q : 2'b00;
      mem_axi_rvalid  = !reset && (rd_state_q == R_RESP);
      mem_axi_rresp   = mem_axi_rvalid ? rresp_q : 2'b00;
      // A decode-error read returns zero data rather than whatever the array aliased to.
      mem_axi_rdata   = (mem_axi_rvalid && rresp_q == OKAY) ? arr_rdata : '0;
   end

endmodule

// File: tb/tb_axil_slave_mem.sv
// Self-checking bench for axil_slave_mem: directed scenarios with literal expectations plus randomized traffic.
// Latency: n/a.
// Backpressure: exercised via held-low bready/rready.
module tb_axil_slave_mem;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int DEPTH     = 1024;
   localparam int READ_LAT  = 2;
   localparam int WRITE_LAT = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        awvalid = 0, awready;
   logic [31:0] awaddr = 0;
   logic [2:0]  awprot = 0;
   logic        wvalid = 0, wready;
   logic [31:0] wdata = 0;
   logic [3:0]  wstrb = 0;
   logic        bvalid, bready = 1;
   logic [1:0]  bresp;
   logic        arvalid = 0, arready;
   logic [31:0] araddr = 0;
   logic [2:0]  arprot = 0;
   logic        rvalid, rready = 1;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   always #5 clk = ~clk;

   int tcyc = 0;
   always @(posedge clk) tcyc <= tcyc + 1;

   int checks = 0;
   int errors = 0;

   axil_slave_mem #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out (t=%0t)", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Tracks what each channel must show in terms of cycle numbers: a response becomes
   // visible a fixed number of cycles after its request completes, and stays until taken.
   logic [31:0] mmem   [DEPTH];
   logic [3:0]  mknown [DEPTH];
   bit          m_aw, m_w, m_wbusy, m_rbusy, r_known;
   int          m_bstart, m_rstart;
   logic [31:0] m_awaddr, m_wdata, m_araddr, r_data;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, r_resp;

   function automatic bit out_of_range(input logic [31:0] a);
      return (a >> 2) >= 32'(DEPTH);
   endfunction

   initial begin : compare
      bit e_awr, e_wr, e_bv, e_arr, e_rv;
      int idx;
      for (int i = 0; i < DEPTH; i++) mknown[i] = 4'h0;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_aw = 0; m_w = 0; m_wbusy = 0; m_rbusy = 0;
            chk("rst_awready", awready, 0);
            chk("rst_wready", wready, 0);
            chk("rst_arready", arready, 0);
            chk("rst_bvalid", bvalid, 0);
            chk("rst_bresp", bresp, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rresp", rresp, 0);
            chk("rst_rdata", rdata, 0);
         end else begin
            e_awr = !m_aw;
            e_wr  = !m_w;
            e_bv  = m_wbusy && (tcyc >= m_bstart);
            e_arr = !m_rbusy;
            e_rv  = m_rbusy && (tcyc >= m_rstart);
            chk("awready", awready, e_awr);
            chk("wready", wready, e_wr);
            chk("bvalid", bvalid, e_bv);
            chk("arready", arready, e_arr);
            chk("rvalid", rvalid, e_rv);
            if (e_bv) chk("bresp", bresp, m_bresp);
            if (e_rv) begin
               chk("rresp", rresp, r_resp);
               if (r_known) chk("rdata", rdata, r_data);
            end
            // events taking effect at the coming edge
            if (awvalid && e_awr) begin m_aw = 1; m_awaddr = awaddr; end
            if (wvalid && e_wr) begin m_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
            if (m_aw && m_w && !m_wbusy) begin
               m_wbusy  = 1;
               m_bstart = tcyc + 1 + WRITE_LAT;
               m_bresp  = out_of_range(m_awaddr) ? 2'b10 : 2'b00;
            end
            if (arvalid && e_arr) begin
               m_rbusy  = 1;
               m_rstart = tcyc + 1 + READ_LAT;
               m_araddr = araddr;
            end
            // read samples before a same-edge write lands
            if (m_rbusy && tcyc == m_rstart - 1) begin
               if (out_of_range(m_araddr)) begin
                  r_data = 0; r_resp = 2'b10; r_known = 1;
               end else begin
                  idx = int'(m_araddr >> 2);
                  r_data = mmem[idx]; r_resp = 2'b00; r_known = (mknown[idx] == 4'hF);
               end
            end
            if (m_wbusy && tcyc == m_bstart - 1 && !out_of_range(m_awaddr)) begin
               idx = int'(m_awaddr >> 2);
               for (int b = 0; b < 4; b++) begin
                  if (m_wstrb[b]) begin
                     mmem[idx][b*8 +: 8] = m_wdata[b*8 +: 8];
                     mknown[idx][b] = 1'b1;
                  end
               end
            end
            if (e_bv && bready) begin m_wbusy = 0; m_aw = 0; m_w = 0; end
            if (e_rv && rready) m_rbusy = 0;
         end
      end
   end

   // ---------------- drivers (entered and left at posedge+1) ----------------
   task automatic drive_aw(input logic [31:0] a, output int c);
      bit got = 0;
      c = -1;
      awvalid = 1; awaddr = a;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (awready) begin got = 1; c = tcyc; end
         @(posedge clk); #1;
      end
      awvalid = 0;
      if (!got) fail("aw_handshake");
   endtask

   task automatic drive_w(input logic [31:0] d, input logic [3:0] s, output int c);
      bit got = 0;
      c = -1;
      wvalid = 1; wdata = d; wstrb = s;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (wready) begin got = 1; c = tcyc; end
         @(posedge clk); #1;
      end
      wvalid = 0;
      if (!got) fail("w_handshake");
   endtask

   task automatic drive_ar(input logic [31:0] a, output int c);
      bit got = 0;
      c = -1;
      arvalid = 1; araddr = a;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (arready) begin got = 1; c = tcyc; end
         @(posedge clk); #1;
      end
      arvalid = 0;
      if (!got) fail("ar_handshake");
   endtask

   task automatic wait_b(input int hold, output logic [1:0] resp, output int c);
      bit got = 0;
      c = -1; resp = 2'bxx;
      bready = (hold == 0);
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (bvalid) begin got = 1; c = tcyc; resp = bresp; end
         @(posedge clk); #1;
      end
      if (!got) fail("b_response");
      else if (hold > 0) begin
         repeat (hold - 1) @(posedge clk);
         #1; bready = 1;
         @(posedge clk); #1;
      end
      bready = 1;
   endtask

   task automatic wait_r(input int hold, output logic [31:0] d, output logic [1:0] resp, output int c);
      bit got = 0;
      c = -1; resp = 2'bxx; d = 'x;
      rready = (hold == 0);
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (rvalid) begin got = 1; c = tcyc; resp = rresp; d = rdata; end
         @(posedge clk); #1;
      end
      if (!got) fail("r_response");
      else if (hold > 0) begin
         repeat (hold - 1) @(posedge clk);
         #1; rready = 1;
         @(posedge clk); #1;
      end
      rready = 1;
   endtask

   // skew > 0 delays W behind AW; skew < 0 delays AW behind W. lat is measured from the later handshake.
   task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int skew, input int hold, output logic [1:0] resp, output int lat);
      int ca, cw, cb;
      fork
         begin
            if (skew < 0) begin repeat (-skew) @(posedge clk); #1; end
            drive_aw(a, ca);
         end
         begin
            if (skew > 0) begin repeat (skew) @(posedge clk); #1; end
            drive_w(d, s, cw);
         end
      join
      wait_b(hold, resp, cb);
      lat = cb - ((ca > cw) ? ca : cw);
   endtask

   task automatic rd_txn(input logic [31:0] a, input int hold, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
      int ca, cr;
      drive_ar(a, ca);
      wait_r(hold, d, resp, cr);
      lat = cr - ca;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios + random traffic ----------------
   initial begin : main
      logic [31:0] d, d_old, d_new;
      logic [1:0]  r, r2, resp, resp2;
      int lat, lat2, ca, cw, cb;
      bit got;

      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rel_awready", awready, 1);
      chk("rel_wready", wready, 1);
      chk("rel_arready", arready, 1);
      @(posedge clk); #1;

      // 1: single write/read
      wr_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
      chk("t1_bresp", resp, 2'b00);
      chk("t1_blat", lat, 2);
      rd_txn(32'h10, 0, d, r, lat);
      chk("t1_rdata", d, 32'hDEADBEEF);
      chk("t1_rresp", r, 2'b00);
      chk("t1_rlat", lat, 3);

      // 2: byte strobes
      wr_txn(32'h20, 32'h11223344, 4'hF, 0, 0, resp, lat);
      wr_txn(32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, resp, lat);
      rd_txn(32'h20, 0, d, r, lat);
      chk("t2_rdata", d, 32'h11BB33DD);

      // 3: W four cycles ahead of AW
      drive_w(32'h0BADF00D, 4'hF, cw);
      @(negedge clk);
      chk("t3_wready_low", wready, 0);
      chk("t3_awready_high", awready, 1);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      drive_aw(32'h40, ca);
      wait_b(0, resp, cb);
      chk("t3_gap", ca - cw, 4);
      chk("t3_blat", cb - ca, 2);
      rd_txn(32'h40, 0, d, r, lat);
      chk("t3_rdata", d, 32'h0BADF00D);

      // 4: decode error; index 1024 must not alias word 0
      wr_txn(32'h0, 32'hCAFE0000, 4'hF, 0, 0, resp, lat);
      wr_txn(32'h1000, 32'h12345678, 4'hF, 0, 0, resp, lat);
      chk("t4_bresp", resp, 2'b10);
      rd_txn(32'h1000, 0, d, r, lat);
      chk("t4_rresp", r, 2'b10);
      chk("t4_rdata", d, 0);
      rd_txn(32'h0, 0, d, r, lat);
      chk("t4_word0", d, 32'hCAFE0000);

      // 5a: read back-pressure
      rready = 0;
      drive_ar(32'h10, ca);
      got = 0;
      for (int i = 0; i < 32 && !got; i++) begin
         @(negedge clk);
         if (rvalid) got = 1;
         else begin @(posedge clk); #1; end
      end
      if (!got) fail("t5_rvalid");
      for (int k = 0; k < 5; k++) begin
         chk("t5_rvalid_hold", rvalid, 1);
         chk("t5_rdata_hold", rdata, 32'hDEADBEEF);
         chk("t5_arready_low", arready, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rready = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_rvalid_done", rvalid, 0);
      chk("t5_arready_back", arready, 1);
      @(posedge clk); #1;

      // 5b: read sampling on the same edge as a write commit
      wr_txn(32'h30, 32'h01010101, 4'hF, 0, 0, resp, lat);
      fork
         begin
            drive_ar(32'h30, ca);
            wait_r(0, d_old, r, lat);
         end
         begin
            @(posedge clk); #1;
            wr_txn(32'h30, 32'h02020202, 4'hF, 0, 0, resp2, lat2);
         end
      join
      chk("t5_collide_old", d_old, 32'h01010101);
      rd_txn(32'h30, 0, d_new, r, lat);
      chk("t5_collide_new", d_new, 32'h02020202);

      // 6: reset while both channels wait
      awvalid = 1; awaddr = 32'h50; wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
      arvalid = 1; araddr = 32'h10;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t6_no_bvalid", bvalid, 0);
         chk("t6_no_rvalid", rvalid, 0);
         if (k == 0) begin
            chk("t6_awready", awready, 1);
            chk("t6_wready", wready, 1);
            chk("t6_arready", arready, 1);
         end
      end
      @(posedge clk); #1;
      wr_txn(32'h60, 32'h66666666, 4'hF, 0, 0, resp, lat);
      chk("t6_bresp", resp, 2'b00);
      chk("t6_blat", lat, 2);
      rd_txn(32'h60, 0, d, r, lat);
      chk("t6_rdata", d, 32'h66666666);
      chk("t6_rlat", lat, 3);

      // random traffic on a small window plus out-of-range addresses
      for (int i = 0; i < 8; i++) wr_txn(32'h100 + 4 * i, $urandom, 4'hF, 0, 0, resp, lat);
      for (int it = 0; it < 150; it++) begin
         logic [31:0] wa, ra;
         int op;
         op = int'($urandom_range(0, 2));
         wa = ($urandom_range(0, 9) == 0) ? 32'h1000 + 4 * $urandom_range(0, 7)
                                          : 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
         ra = ($urandom_range(0, 9) == 0) ? 32'h1000 + 4 * $urandom_range(0, 7)
                                          : 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
         case (op)
            0: wr_txn(wa, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                      int'($urandom_range(0, 3)), resp, lat);
            1: rd_txn(ra, int'($urandom_range(0, 3)), d, r, lat);
            default: fork
               wr_txn(wa, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                      int'($urandom_range(0, 3)), resp, lat);
               begin
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  #1;
                  rd_txn(ra, int'($urandom_range(0, 3)), d, r, lat2);
               end
            join
         endcase
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_slave_mem.md
Name: axil_slave_mem

Overview:
Parametrised AXI-Lite slave memory model, successor to the fixed 32-bit mem_axi channel bundle.
- Serves the core's mem_axi port in block-level and SoC benches.
- Adds configurable data width, depth and per-channel wait-state latency.
- Handles byte strobes, independent AW/W acceptance and SLVERR decode errors.
- Read and write channels run concurrently, one outstanding transaction each.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64)
DEPTH, 1024, number of DATA_W words
READ_LAT, 2, extra cycles between AR accept and rvalid (0..15)
WRITE_LAT, 1, extra cycles between AW+W both captured and bvalid (0..15)

Ports:
clk  in  1  clock
reset  in  1  reset
mem_axi_awvalid  in  1  write address valid
mem_axi_awready  out  1  write address ready
mem_axi_awaddr  in  ADDR_W  write byte address
mem_axi_awprot  in  3  ignored
mem_axi_wvalid  in  1  write data valid
mem_axi_wready  out  1  write data ready
mem_axi_wdata  in  DATA_W  write data
mem_axi_wstrb  in  DATA_W/8  byte strobes
mem_axi_bvalid  out  1  write response valid
mem_axi_bready  in  1  write response ready
mem_axi_bresp  out  2  OKAY=00, SLVERR=10
mem_axi_arvalid  in  1  read address valid
mem_axi_arready  out  1  read address ready
mem_axi_araddr  in  ADDR_W  read byte address
mem_axi_arprot  in  3  ignored
mem_axi_rvalid  out  1  read data valid
mem_axi_rready  in  1  read data ready
mem_axi_rdata  out  DATA_W  read data
mem_axi_rresp  out  2  OKAY=00, SLVERR=10

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (reset).
- While reset is high, all outputs are 0 and FSMs go to IDLE.
- Pending transactions are dropped with no response. Memory contents are not cleared.
- First cycle after reset deasserts: awready=wready=arready=1.
- Addressing: word index = addr[ADDR_W-1:log2(DATA_W/8)]; low bits are ignored, no alignment error.
- Decode error: index >= DEPTH gives resp SLVERR. On such a write, memory is unchanged; on such a read, rdata=0.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: awready=!aw_captured, wready=!w_captured. AW and W are accepted independently, in any order or the same cycle; addr and data/strb are latched on each handshake.
  - Once both are captured: go to W_RESP if WRITE_LAT=0, else W_WAIT with the counter loaded to WRITE_LAT-1.
  - W_WAIT: decrement the counter; at 0, go to W_RESP.
  - On entry to W_RESP: byte lanes with wstrb=1 are written in the same clock edge. bvalid=1, and bresp is held stable until bready. wstrb=0 gives OKAY with no change.
  - On bvalid && bready: go to W_IDLE, clear the captured flags, readies back to 1 next cycle.
  - Minimum AW/W to bvalid: 1 cycle with WRITE_LAT=0; 1+WRITE_LAT in general.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1; the AR handshake latches the address.
  - Go to R_RESP if READ_LAT=0, else R_WAIT for READ_LAT cycles.
  - rdata is sampled from the array on the edge entering R_RESP. rvalid, rdata and rresp are held stable until rready.
  - On rvalid && rready: go to R_IDLE.
  - AR to rvalid: 1+READ_LAT cycles.
- Read/write collision: a read sampling the same word in the same edge as a write commit returns the old data (read-before-write). The next read sees the new data.
- Back-pressure: bready/rready held low stalls the channel indefinitely, and no new AW/W/AR is accepted on that channel. The other channel is unaffected.
- Counters are $clog2(16) bits wide; a latency above 15 is a compile-time error via assertion.

Decomposition:
- axil_pkg holds:
  - axil_resp_e (OKAY, SLVERR)
  - wr_state_e (W_IDLE, W_WAIT, W_RESP)
  - rd_state_e (R_IDLE, R_WAIT, R_RESP)
  - the LAT_MAX=15 constant
- One sub-module, axil_mem_array: a 1R/1W word array with per-byte write enable, DEPTH x DATA_W, synchronous read, read-before-write.

Test Plan:
All scenarios use defaults (DATA_W=32, DEPTH=1024, READ_LAT=2, WRITE_LAT=1).
1. Reset then single write/read: AW=0x10 and W=0xDEADBEEF with strb=F in the same cycle → bvalid 2 cycles later with bresp=00. AR=0x10 → rvalid 3 cycles after AR with rdata=0xDEADBEEF, rresp=00.
2. Byte strobes: write 0x11223344 strb=F, then 0xAABBCCDD strb=0101 to 0x20 → read 0x20 returns 0x11BB33DD.
3. Split AW/W: W presented 4 cycles before AW → wready drops after the W handshake, awready stays 1. bvalid follows 2 cycles after AW, and data is written correctly.
4. Decode error: write to 0x1000 (index 1024) → bresp=10, memory unchanged. Read 0x1000 → rresp=10, rdata=0.
5. Back-pressure and collision: hold rready=0 for 5 cycles → rvalid/rdata stable, arready=0. Separately, a read and write to the same word committing on the same edge → the read returns the old value and the following read returns the new one.
6. Reset mid-transaction: assert reset during R_WAIT and W_WAIT → no rvalid/bvalid afterwards, all readies 1 in the cycle after release, and a subsequent write/read completes normally.
